// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM controller port between the C64 bus, ioctl and REU DMA requesters.
// Define REU_PORT_EN to arbitrate the REU port (p2); otherwise p2 is ignored and its outputs tie to 0.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W        = 25,
    parameter int unsigned MAX_C64_BURST = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_wdata,
    output logic [7:0]        p0_rdata,
    output logic              p0_ack,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_wdata,
    output logic [7:0]        p1_rdata,
    output logic              p1_ack,
    output logic              p1_err,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [7:0]        p2_wdata,
    output logic [7:0]        p2_rdata,
    output logic              p2_ack,
    output logic              p2_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int unsigned RUN_W = $clog2(MAX_C64_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_C64_BURST);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          win_q, win_d;
    logic [7:0]          timer_q, timer_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic [2:0]          ack_q, ack_d;
    logic [2:0]          err_q, err_d;
    logic [2:0][7:0]     rdata_q, rdata_d;
    logic                busy_q, busy_d;

    logic                p2_req_eff;
    logic                bg_pend;
    logic                any_req;
    logic [1:0]          rr_pick;
    logic [1:0]          grant;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [7:0]          sel_wdata;

`ifdef REU_PORT_EN
    logic last_bg_q, last_bg_d;   // 1 = p2 was the last background grant
    assign p2_req_eff = p2_req;
    assign rr_pick    = last_bg_q ? 2'd1 : 2'd2;
    assign p2_rdata   = rdata_q[2];
    assign p2_ack     = ack_q[2];
    assign p2_err     = err_q[2];
`else
    logic unused_p2;
    assign unused_p2  = ^{p2_req, ack_q[2], err_q[2], rdata_q[2]};
    assign p2_req_eff = 1'b0;
    assign rr_pick    = 2'd1;
    assign p2_rdata   = 8'h00;
    assign p2_ack     = 1'b0;
    assign p2_err     = 1'b0;
`endif

    // Winner: C64 first unless its burst allowance is spent while a background port waits.
    always_comb begin
        bg_pend = p1_req | p2_req_eff;
        any_req = p0_req | bg_pend;
        if (p0_req && !(bg_pend && run_q == RUN_MAX)) begin
            grant = 2'd0;
        end else if (p1_req && p2_req_eff) begin
            grant = rr_pick;
        end else if (p1_req) begin
            grant = 2'd1;
        end else begin
            grant = 2'd2;
        end
    end

    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        case (grant)
            2'd1: begin
                sel_we    = p1_we;
                sel_addr  = p1_addr;
                sel_wdata = p1_wdata;
            end
            2'd2: begin
                sel_we    = p2_we;
                sel_addr  = p2_addr;
                sel_wdata = p2_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        timer_d    = timer_q;
        run_d      = run_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack_d      = '0;
        err_d      = '0;
        rdata_d    = rdata_q;
`ifdef REU_PORT_EN
        last_bg_d  = last_bg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d    = S_WAIT;
                    win_d      = grant;
                    timer_d    = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = sel_we;
                    mem_addr_d = sel_addr;
                    mem_din_d  = sel_wdata;
                    if (grant == 2'd0) begin
                        if (bg_pend && run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
                    end else begin
                        run_d = '0;
`ifdef REU_PORT_EN
                        last_bg_d = (grant == 2'd2);
`endif
                    end
                end
            end
            S_WAIT: begin
                // A controller ack on the timeout edge still counts as a normal completion.
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    ack_d[win_q] = 1'b1;
                    if (!mem_we_q) rdata_d[win_q] = mem_dout;
                    state_d      = S_DONE;
                end else if (timer_q == TMO_LAST) begin
                    mem_req_d      = 1'b0;
                    ack_d[win_q]   = 1'b1;
                    err_d[win_q]   = 1'b1;
                    rdata_d[win_q] = 8'hFF;
                    state_d        = S_DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!bg_pend) run_d = '0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            win_q      <= 2'd0;
            timer_q    <= '0;
            run_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
`ifdef REU_PORT_EN
            last_bg_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            timer_q    <= timer_d;
            run_q      <= run_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
`ifdef REU_PORT_EN
            last_bg_q  <= last_bg_d;
`endif
        end
    end

    assign p0_rdata = rdata_q[0];
    assign p0_ack   = ack_q[0];
    assign p0_err   = err_q[0];
    assign p1_rdata = rdata_q[1];
    assign p1_ack   = ack_q[1];
    assign p1_err   = err_q[1];
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule
